// File: rtl/can_tdc_pkg.sv
// Shared types and constants for the CAN edge transmitter and its bit timer.
package can_tdc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DATA  = 2'd1,
      ST_STUFF = 2'd2,
      ST_IFS   = 2'd3
   } tx_state_t;

   localparam int CAN_FINE_MAX  = 100;
   localparam int CAN_IFS_BITS  = 11;
   localparam int CAN_STUFF_RUN = 5;

   // Clamp a tap code to the last tap that physically exists in the chain.
   function automatic logic [6:0] sat_fine(input logic [6:0] code, input int max_code);
      if (int'(code) > max_code) return 7'(max_code);
      return code;
   endfunction

endpackage

// File: rtl/can_bit_timer.sv
// Bit-period down-counter; bit_end marks the last CLK cycle of every bit.
module can_bit_timer #(
   parameter int PERIOD_W = 16
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                load,
   input  logic                en,
   input  logic [PERIOD_W-1:0] period,
   output logic                bit_end
);
   logic [PERIOD_W-1:0] cnt_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt_q <= '0;
      end else if (load || (en && (cnt_q == '0))) begin
         cnt_q <= period - PERIOD_W'(1);
      end else if (en) begin
         cnt_q <= cnt_q - PERIOD_W'(1);
      end
   end

   assign bit_end = en && (cnt_q == '0);

endmodule

// File: rtl/can_edge_tx.sv
// CAN-style serializer with bit stuffing and inter-frame space; every line
// transition is flagged with a strobe and a fine tap code for an edge emitter.
//
// state    | meaning
// ST_IDLE  | line recessive, waiting for a held byte
// ST_DATA  | shifting data bits MSB first
// ST_STUFF | one complementary stuff bit after a run of equal bits
// ST_IFS   | recessive inter-frame bits, then tx_done
module can_edge_tx
   import can_tdc_pkg::*;
#(
   parameter int PERIOD_W = 16,
   parameter int FINE_MAX = CAN_FINE_MAX,
   parameter int IFS_BITS = CAN_IFS_BITS
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic [PERIOD_W-1:0] bit_period,
   input  logic [6:0]          fine_delay,
   input  logic                stuff_en,
   input  logic [7:0]          tx_data,
   input  logic                tx_valid,
   input  logic                tx_last,
   output logic                tx_ready,
   output logic                CAN_tx,
   output logic                edge_strobe,
   output logic [6:0]          edge_fine,
   output logic                busy,
   output logic                tx_done,
   output logic                underrun
);
   localparam int IFS_W = (IFS_BITS > 1) ? $clog2(IFS_BITS) : 1;

   tx_state_t state_q, state_d;

   logic                hold_full_q, hold_last_q;
   logic [7:0]          hold_data_q;
   logic [7:0]          shift_q;
   logic [2:0]          bit_idx_q;
   logic                last_q;
   logic [2:0]          run_q;
   logic [IFS_W-1:0]    ifs_q;
   logic [PERIOD_W-1:0] period_q;
   logic [6:0]          fine_q;
   logic                stuff_q;
   logic                can_q, strobe_q, done_q, underrun_q;

   logic                accept, frame_start, bit_end, need_stuff, byte_done;
   logic                stuff_go, advance, load_next, frame_end, ifs_end;
   logic                line_d;
   logic [PERIOD_W-1:0] period_sel;

   assign accept      = tx_valid && !hold_full_q;
   assign frame_start = (state_q == ST_IDLE) && hold_full_q;
   assign need_stuff  = stuff_q && (run_q == 3'(CAN_STUFF_RUN));
   assign byte_done   = (bit_idx_q == 3'd7);
   assign stuff_go    = bit_end && (state_q == ST_DATA) && need_stuff;
   assign advance     = bit_end && (((state_q == ST_DATA) && !need_stuff) ||
                                    (state_q == ST_STUFF));
   // A tx_last byte always closes the frame, even if the next frame's byte is already held.
   assign frame_end   = advance && byte_done && (last_q || !hold_full_q);
   assign load_next   = advance && byte_done && !last_q && hold_full_q;
   assign ifs_end     = bit_end && (state_q == ST_IFS) && (ifs_q == '0);

   // The timer must see the freshly clamped period in the cycle the frame starts.
   assign period_sel = frame_start ?
                       ((bit_period < PERIOD_W'(2)) ? PERIOD_W'(2) : bit_period) :
                       period_q;

   can_bit_timer #(.PERIOD_W(PERIOD_W)) u_timer (
      .CLK     (CLK),
      .RST     (RST),
      .load    (frame_start),
      .en      (busy),
      .period  (period_sel),
      .bit_end (bit_end)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (hold_full_q) state_d = ST_DATA;
         ST_DATA: begin
            if (stuff_go)       state_d = ST_STUFF;
            else if (frame_end) state_d = ST_IFS;
         end
         ST_STUFF: if (bit_end) state_d = frame_end ? ST_IFS : ST_DATA;
         ST_IFS:   if (ifs_end) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q != ST_IDLE);
   end

   always_comb begin
      line_d = can_q;
      if (frame_start) begin
         line_d = hold_data_q[7];
      end else if (stuff_go) begin
         line_d = ~can_q;
      end else if (advance) begin
         if (!byte_done)     line_d = shift_q[6];
         else if (load_next) line_d = hold_data_q[7];
         else                line_d = 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         hold_full_q <= 1'b0;
         hold_last_q <= 1'b0;
         hold_data_q <= '0;
         shift_q     <= '0;
         bit_idx_q   <= '0;
         last_q      <= 1'b0;
         run_q       <= '0;
         ifs_q       <= '0;
         period_q    <= PERIOD_W'(2);
         fine_q      <= '0;
         stuff_q     <= 1'b0;
         can_q       <= 1'b1;
         strobe_q    <= 1'b0;
         done_q      <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         if (frame_start || load_next) hold_full_q <= 1'b0;
         if (accept) begin
            hold_full_q <= 1'b1;
            hold_data_q <= tx_data;
            hold_last_q <= tx_last;
         end

         if (frame_start) begin
            period_q <= period_sel;
            fine_q   <= sat_fine(fine_delay, FINE_MAX);
            stuff_q  <= stuff_en;
         end

         if (frame_start || load_next) begin
            shift_q   <= hold_data_q;
            last_q    <= hold_last_q;
            bit_idx_q <= '0;
         end else if (advance && !byte_done) begin
            shift_q   <= {shift_q[6:0], 1'b0};
            bit_idx_q <= bit_idx_q + 3'd1;
         end

         // Run length counts stuff bits too; the idle line never counts.
         if (frame_start) begin
            run_q <= 3'd1;
         end else if (stuff_go || advance) begin
            if (line_d != can_q)                    run_q <= 3'd1;
            else if (run_q != 3'(CAN_STUFF_RUN))    run_q <= run_q + 3'd1;
         end

         if (frame_end)                         ifs_q <= IFS_W'(IFS_BITS - 1);
         else if (bit_end && (state_q == ST_IFS) && (ifs_q != '0))
                                                ifs_q <= ifs_q - IFS_W'(1);

         can_q      <= line_d;
         strobe_q   <= (line_d != can_q);
         done_q     <= ifs_end;
         underrun_q <= frame_end && !last_q;
      end
   end

   assign tx_ready    = !hold_full_q;
   assign CAN_tx      = can_q;
   assign edge_strobe = strobe_q;
   assign edge_fine   = fine_q;
   assign tx_done     = done_q;
   assign underrun    = underrun_q;

endmodule

// File: tb/tb_can_edge_tx.sv
// Scoreboard bench: a bit-list reference model fills a per-cycle expectation
// queue; a negedge monitor compares it against the line whenever busy is seen.
module tb_can_edge_tx;
   localparam int PW    = 16;
   localparam int IFS_N = 11;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic [PW-1:0] bit_period = '0;
   logic [6:0]    fine_delay = '0;
   logic          stuff_en = 1'b0;
   logic [7:0]    tx_data = '0;
   logic          tx_valid = 1'b0;
   logic          tx_last = 1'b0;
   logic          tx_ready, CAN_tx, edge_strobe, busy, tx_done, underrun;
   logic [6:0]    edge_fine;

   can_edge_tx #(.PERIOD_W(PW), .FINE_MAX(100), .IFS_BITS(IFS_N)) dut (
      .CLK(CLK), .RST(RST), .bit_period(bit_period), .fine_delay(fine_delay),
      .stuff_en(stuff_en), .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
      .tx_ready(tx_ready), .CAN_tx(CAN_tx), .edge_strobe(edge_strobe),
      .edge_fine(edge_fine), .busy(busy), .tx_done(tx_done), .underrun(underrun)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic       can;
      logic       stb;
      logic       und;
      logic       fin;
      logic [6:0] fine;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] fb[$];
   int         n_checks = 0;
   int         n_fail = 0;
   int         strobe_cnt = 0, done_cnt = 0, und_cnt = 0;
   bit         mon_en = 1'b0;
   logic       prev_busy = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: wait bound expired at %0t", name, $time);
   endtask

   // Reference: build the whole line as a list of bits, then expand to cycles.
   task automatic model_frame(input int p_raw, input int f_raw, input bit s, input bit ends_last);
      bit   line[$];
      int   run, p, f, ifs_start;
      bit   prev, b;
      exp_t e;
      p   = (p_raw < 2) ? 2 : p_raw;
      f   = (f_raw > 100) ? 100 : f_raw;
      run = 0;
      foreach (fb[k]) begin
         for (int i = 7; i >= 0; i--) begin
            b   = fb[k][i];
            run = (line.size() != 0 && line[$] == b) ? run + 1 : 1;
            line.push_back(b);
            if (s && run == 5) begin
               line.push_back(!b);
               run = 1;
            end
         end
      end
      ifs_start = line.size();
      repeat (IFS_N) line.push_back(1'b1);
      prev = 1'b1;
      foreach (line[k]) begin
         for (int c = 0; c < p; c++) begin
            e.can  = line[k];
            e.stb  = (c == 0) && (line[k] != prev);
            e.und  = !ends_last && (k == ifs_start) && (c == 0);
            e.fin  = 1'b0;
            e.fine = 7'(f);
            exp_q.push_back(e);
         end
         prev = line[k];
      end
      e.can = 1'b1; e.stb = 1'b0; e.und = 1'b0; e.fin = 1'b1; e.fine = 7'(f);
      exp_q.push_back(e);
   endtask

   always @(negedge CLK) begin : monitor
      exp_t a, e;
      a.can = CAN_tx; a.stb = edge_strobe; a.und = underrun; a.fin = tx_done; a.fine = edge_fine;
      if (edge_strobe) strobe_cnt++;
      if (tx_done)     done_cnt++;
      if (underrun)    und_cnt++;
      if (mon_en && !RST) begin
         if (busy || prev_busy) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL frame_extra: actual=busy cycle required=no cycles left at %0t", $time);
            end else begin
               e = exp_q.pop_front();
               chk(busy ? "frame_cycle" : "frame_end", 32'(a), 32'(e));
            end
         end else begin
            chk("idle_line", {28'd0, CAN_tx, edge_strobe, underrun, tx_done}, 32'h8);
         end
      end
      prev_busy = busy;
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!tx_ready && n < 3000) begin
         tick();
         n++;
      end
      if (!tx_ready) timeout_fail("ready_wait");
   endtask

   task automatic send_byte(input logic [7:0] d, input bit last);
      wait_ready();
      tx_data  = d;
      tx_last  = last;
      tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
      tx_last  = 1'b0;
   endtask

   task automatic run_frame(input int p, input int f, input bit s, input bit ends_last);
      int n = 0;
      model_frame(p, f, s, ends_last);
      bit_period = PW'(p);
      fine_delay = 7'(f);
      stuff_en   = s;
      foreach (fb[k]) begin
         send_byte(fb[k], ends_last && (k == fb.size() - 1));
         if (k == 0) begin
            wait_ready();
            // Config is latched at frame start; scramble it to prove that.
            bit_period = PW'($urandom_range(0, 9));
            fine_delay = 7'($urandom);
            stuff_en   = 1'($urandom_range(0, 1));
         end
      end
      if (!ends_last) begin
         while (!underrun && n < 3000) begin
            tick();
            n++;
         end
         if (!underrun) timeout_fail("underrun_wait");
      end
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || busy) && n < 5000) begin
         tick();
         n++;
      end
      if (exp_q.size() != 0 || busy) timeout_fail("drain");
      tick();
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish at %0t", $time);
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int s0, d0, u0;
      logic [7:0] rb;
      repeat (3) @(negedge CLK);
      chk("reset_flags", {26'd0, CAN_tx, tx_ready, edge_strobe, busy, tx_done, underrun},
          32'h30);
      chk("reset_fine", 32'(edge_fine), 32'd0);
      @(posedge CLK);
      #1 RST = 1'b0;
      mon_en = 1'b1;
      tick();

      // Period 4, fine 37, no stuffing, 0xA5 with tx_last.
      s0 = strobe_cnt; d0 = done_cnt;
      fb.delete(); fb.push_back(8'hA5);
      run_frame(4, 37, 1'b0, 1'b1);
      drain();
      chk("s1_strobes", 32'(strobe_cnt - s0), 32'd6);
      chk("s1_done", 32'(done_cnt - d0), 32'd1);

      // All-zero byte with stuffing, including the stuff rule at frame end.
      fb.delete(); fb.push_back(8'h00);
      run_frame(3, 5, 1'b1, 1'b1);
      drain();

      // Back-to-back bytes across the byte boundary with stuffing.
      fb.delete(); fb.push_back(8'hFF); fb.push_back(8'h0F);
      run_frame(3, 10, 1'b1, 1'b1);
      drain();

      // Underrun: no tx_last and no follow-up byte.
      u0 = und_cnt; d0 = done_cnt;
      fb.delete(); fb.push_back(8'($urandom));
      run_frame(3, 20, 1'b1, 1'b0);
      drain();
      chk("s4_underrun", 32'(und_cnt - u0), 32'd1);
      chk("s4_done", 32'(done_cnt - d0), 32'd1);

      // Saturation of fine code and minimum period.
      fb.delete(); fb.push_back(8'h3C);
      run_frame(0, 120, 1'b0, 1'b1);
      drain();
      chk("s5_fine_sat", 32'(edge_fine), 32'd100);

      // Random frames, issued without draining so frames chain through IFS.
      for (int fr = 0; fr < 25; fr++) begin
         int nb;
         nb = $urandom_range(1, 3);
         fb.delete();
         for (int i = 0; i < nb; i++) begin
            case ($urandom_range(0, 3))
               0:       rb = 8'h00;
               1:       rb = 8'hFF;
               default: rb = 8'($urandom);
            endcase
            fb.push_back(rb);
         end
         run_frame($urandom_range(0, 6), $urandom_range(0, 127),
                   1'($urandom_range(0, 1)), ($urandom_range(0, 4) != 0));
      end
      drain();

      // Mid-frame reset during bit 3 with a second byte held.
      mon_en     = 1'b0;
      bit_period = PW'(4);
      fine_delay = 7'd9;
      stuff_en   = 1'b0;
      send_byte(8'hA5, 1'b0);
      wait_ready();
      send_byte(8'h3C, 1'b1);
      repeat (11) tick();
      chk("s6_pre_reset_bit3", 32'(CAN_tx), 32'd0);
      #2 RST = 1'b1;
      #1;
      chk("s6_async_reset", {28'd0, CAN_tx, tx_ready, busy, edge_strobe}, 32'hC);
      @(posedge CLK);
      #1 RST = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         chk("s6_post_reset_quiet", {28'd0, CAN_tx, edge_strobe, busy, tx_ready}, 32'h9);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
